// File: rtl/remote_cmd_sender_if.sv
// Request, UART TX/RX handshake and response signals of the remote command
// sender. The master modport is the sender itself; the slave modport is the
// surrounding control logic and UART pair.
interface remote_cmd_sender_if;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        tx_done;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        clr_rx_rdy;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        pos_ack;
    logic        tmo;
    logic        busy;

    modport master (
        input  snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
        output tx_data, trmt, clr_rx_rdy, resp, resp_rdy, pos_ack, tmo, busy
    );

    modport slave (
        output snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
        input  tx_data, trmt, clr_rx_rdy, resp, resp_rdy, pos_ack, tmo, busy
    );
endinterface

// File: rtl/remote_cmd_sender.sv
// Remote-side initiator of the 24-bit command protocol: sends cmd, data[15:8],
// data[7:0] over the UART, then waits for a one-byte response (A5 = positive
// ack, or battery level) or gives up after 2^TMO_WIDTH-1 cycles of silence.
module remote_cmd_sender #(
    parameter int unsigned TMO_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    remote_cmd_sender_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_HI,
        TX_LO,
        WAIT_RESP
    } state_t;

    localparam logic [7:0] POS_ACK_BYTE = 8'hA5;

    state_t               state_q,      state_d;
    logic [TMO_WIDTH-1:0] timer_q,      timer_d;
    logic [15:0]          data_q,       data_d;
    logic [7:0]           tx_data_q,    tx_data_d;
    logic [7:0]           resp_q,       resp_d;
    logic                 trmt_q,       trmt_d;
    logic                 clr_rx_rdy_q, clr_rx_rdy_d;
    logic                 resp_rdy_q,   resp_rdy_d;
    logic                 pos_ack_q,    pos_ack_d;
    logic                 tmo_q,        tmo_d;
    logic                 busy_q,       busy_d;

    // State, timer, latched payload and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            data_q       <= '0;
            tx_data_q    <= '0;
            resp_q       <= '0;
            trmt_q       <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            resp_rdy_q   <= 1'b0;
            pos_ack_q    <= 1'b0;
            tmo_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            data_q       <= data_d;
            tx_data_q    <= tx_data_d;
            resp_q       <= resp_d;
            trmt_q       <= trmt_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            resp_rdy_q   <= resp_rdy_d;
            pos_ack_q    <= pos_ack_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic; pulses default low, held values default to hold.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        data_d       = data_q;
        tx_data_d    = tx_data_q;
        resp_d       = resp_q;
        trmt_d       = 1'b0;
        clr_rx_rdy_d = 1'b0;
        resp_rdy_d   = 1'b0;
        pos_ack_d    = 1'b0;
        tmo_d        = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                // A byte waiting in IDLE belongs to no transaction: drop it.
                if (bus.rx_rdy) begin
                    clr_rx_rdy_d = 1'b1;
                end
                // The opcode goes straight into tx_data, so only data needs its own latch.
                if (bus.snd_cmd) begin
                    data_d    = bus.data;
                    tx_data_d = bus.cmd;
                    trmt_d    = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = TX_CMD;
                end
            end

            TX_CMD: begin
                if (bus.tx_done) begin
                    tx_data_d = data_q[15:8];
                    trmt_d    = 1'b1;
                    state_d   = TX_HI;
                end
            end

            TX_HI: begin
                if (bus.tx_done) begin
                    tx_data_d = data_q[7:0];
                    trmt_d    = 1'b1;
                    state_d   = TX_LO;
                end
            end

            TX_LO: begin
                if (bus.tx_done) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                // Response is checked first so it wins over a simultaneous timeout.
                if (bus.rx_rdy) begin
                    resp_d       = bus.rx_data;
                    resp_rdy_d   = 1'b1;
                    clr_rx_rdy_d = 1'b1;
                    pos_ack_d    = (bus.rx_data == POS_ACK_BYTE);
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else if (&timer_q) begin
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMO_WIDTH'(1);
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.clr_rx_rdy = clr_rx_rdy_q;
    assign bus.resp       = resp_q;
    assign bus.resp_rdy   = resp_rdy_q;
    assign bus.pos_ack    = pos_ack_q;
    assign bus.tmo        = tmo_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_remote_cmd_sender.sv
// Directed bench for remote_cmd_sender: a UART TX model answers every trmt
// with tx_done 20 cycles later, a scoreboard holds the expected transmitted
// bytes and responses, and the main sequence drives requests and RX bytes.
module tb_remote_cmd_sender;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx_done_r = 1'b0;

    always #5 clk = ~clk;

    remote_cmd_sender_if bus ();

    remote_cmd_sender #(.TMO_WIDTH(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    assign bus.tx_done = tx_done_r;

    typedef struct packed {
        logic [7:0] r;
        logic       a;
    } resp_t;

    logic [7:0] exp_tx[$];
    resp_t      exp_resp[$];

    int total   = 0;
    int bad     = 0;
    int n_trmt  = 0;
    int n_done  = 0;
    int tx_cnt  = 0;
    int nd_base = 0;
    int tr_base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // UART TX model: one tx_done pulse 20 cycles after each trmt.
    always @(posedge clk) begin
        #1;
        tx_done_r = 1'b0;
        if (!rst_n) begin
            tx_cnt = 0;
        end else begin
            if (tx_cnt != 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done_r = 1'b1;
                    n_done++;
                end
            end
            if (bus.trmt) tx_cnt = 20;
        end
    end

    // Scoreboard side: every trmt and resp_rdy must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.trmt) begin
                n_trmt++;
                if (exp_tx.size() == 0) chk("trmt_unexpected", 32'(bus.trmt), 32'(0));
                else chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.resp_rdy) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_rdy_unexpected", 32'(bus.resp_rdy), 32'(0));
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_byte", 32'(bus.resp), 32'(e.r));
                    chk("resp_pos_ack", 32'(bus.pos_ack), 32'(e.a));
                    chk("resp_clr_rx", 32'(bus.clr_rx_rdy), 32'(1));
                    chk("resp_busy", 32'(bus.busy), 32'(0));
                end
            end
        end
    end

    // One cycle; the RX model drops rx_rdy once the DUT consumes the byte.
    task automatic tick();
        @(negedge clk);
        if (bus.clr_rx_rdy) bus.rx_rdy = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx_data"},  32'(bus.tx_data),    32'(0));
        chk({tag, "_trmt"},     32'(bus.trmt),       32'(0));
        chk({tag, "_clr"},      32'(bus.clr_rx_rdy), 32'(0));
        chk({tag, "_resp"},     32'(bus.resp),       32'(0));
        chk({tag, "_resp_rdy"}, 32'(bus.resp_rdy),   32'(0));
        chk({tag, "_pos_ack"},  32'(bus.pos_ack),    32'(0));
        chk({tag, "_tmo"},      32'(bus.tmo),        32'(0));
        chk({tag, "_busy"},     32'(bus.busy),       32'(0));
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
        nd_base = n_done;
        tr_base = n_trmt;
        bus.snd_cmd = 1'b1;
        bus.cmd     = c;
        bus.data    = d;
        exp_tx.push_back(c);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
        tick();
        bus.snd_cmd = 1'b0;
        bus.cmd     = 8'hEE;
        bus.data    = 16'hDEAD;
        chk("accept_trmt", 32'(bus.trmt), 32'(1));
        chk("accept_busy", 32'(bus.busy), 32'(1));
        chk("accept_no_resp_rdy", 32'(bus.resp_rdy), 32'(0));
    endtask

    // Returns on the negedge of the cycle in which tx_done number 'target' is high.
    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && n_done < target; i++) tick();
        chk("tx_done_reached", 32'(n_done >= target), 32'(1));
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 20 && !bus.resp_rdy; i++) tick();
        chk("resp_rdy_seen", 32'(bus.resp_rdy), 32'(1));
        chk("busy_low_after_resp", 32'(bus.busy), 32'(0));
    endtask

    task automatic do_resp(input logic [7:0] b);
        resp_t e;
        e.r = b;
        e.a = (b == 8'hA5);
        exp_resp.push_back(e);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        wait_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.snd_cmd = 1'b0;
        bus.cmd     = '0;
        bus.data    = '0;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = '0;

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // 1: full transaction with positive ack.
        send_cmd(8'h02, 16'h1234);
        wait_done(nd_base + 3);
        do_resp(8'hA5);
        chk("t1_trmt_count", 32'(n_trmt - tr_base), 32'(3));

        // 2: accepted in the first IDLE cycle; response arrives early during TX_HI and stays pending.
        send_cmd(8'h01, 16'hBEEF);
        wait_done(nd_base + 1);
        begin
            resp_t e;
            e.r = 8'hC3;
            e.a = 1'b0;
            exp_resp.push_back(e);
        end
        bus.rx_data = 8'hC3;
        bus.rx_rdy  = 1'b1;
        wait_done(nd_base + 3);
        chk("t2_rx_pending", 32'(bus.rx_rdy), 32'(1));
        wait_resp();
        tick();
        chk("t2_resp_rdy_pulse", 32'(bus.resp_rdy), 32'(0));
        chk("t2_clr_pulse", 32'(bus.clr_rx_rdy), 32'(0));

        // 3: no response; timer cleared entering WAIT_RESP, saturates 511 cycles later, tmo the cycle after.
        send_cmd(8'h05, 16'h01FF);
        wait_done(nd_base + 3);
        repeat (512) tick();
        chk("t3_tmo_not_early", 32'(bus.tmo), 32'(0));
        chk("t3_busy_held", 32'(bus.busy), 32'(1));
        tick();
        chk("t3_tmo", 32'(bus.tmo), 32'(1));
        chk("t3_busy_drop", 32'(bus.busy), 32'(0));
        chk("t3_resp_kept", 32'(bus.resp), 32'(8'hC3));
        chk("t3_no_resp_rdy", 32'(bus.resp_rdy), 32'(0));
        tick();
        chk("t3_tmo_pulse", 32'(bus.tmo), 32'(0));

        // 4: stale byte in IDLE, then a second request during TX_HI that must be ignored.
        bus.rx_data = 8'h77;
        bus.rx_rdy  = 1'b1;
        tick();
        chk("t4_stale_clr", 32'(bus.clr_rx_rdy), 32'(1));
        chk("t4_stale_no_rdy", 32'(bus.resp_rdy), 32'(0));
        chk("t4_stale_resp", 32'(bus.resp), 32'(8'hC3));
        tick();
        send_cmd(8'h03, 16'hABCD);
        wait_done(nd_base + 1);
        repeat (3) tick();
        bus.snd_cmd = 1'b1;
        bus.cmd     = 8'h09;
        bus.data    = 16'h5555;
        tick();
        bus.snd_cmd = 1'b0;
        wait_done(nd_base + 3);
        do_resp(8'hA5);
        repeat (30) tick();
        chk("t4_trmt_count", 32'(n_trmt - tr_base), 32'(3));

        // 5: response arrives in the very cycle the timer saturates.
        send_cmd(8'h04, 16'h1111);
        wait_done(nd_base + 3);
        repeat (512) tick();
        begin
            resp_t e;
            e.r = 8'h5A;
            e.a = 1'b0;
            exp_resp.push_back(e);
        end
        bus.rx_data = 8'h5A;
        bus.rx_rdy  = 1'b1;
        tick();
        chk("t5_resp_rdy", 32'(bus.resp_rdy), 32'(1));
        chk("t5_no_tmo", 32'(bus.tmo), 32'(0));
        tick();
        chk("t5_no_tmo_late", 32'(bus.tmo), 32'(0));

        // 6: asynchronous reset during WAIT_RESP, then a clean transaction.
        send_cmd(8'h06, 16'h0102);
        wait_done(nd_base + 3);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_cmd(8'h08, 16'h0000);
        wait_done(nd_base + 3);
        do_resp(8'hA5);
        chk("t6_trmt_count", 32'(n_trmt - tr_base), 32'(3));

        tick();
        chk("exp_tx_drained", 32'(exp_tx.size()), 32'(0));
        chk("exp_resp_drained", 32'(exp_resp.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
